uart_tx_fifo: RTL and testbench

Buffered front-end for the general-purpose UART transmitter in the tinyQV peripheral set.
- Upstream: the CPU peripheral write path (byte writes to the UART data address).
- Downstream: feeds the existing uart_tx en/data/busy handshake.
- Lets firmware queue up to DEPTH bytes without polling busy between bytes.
- Exposes level, full/empty, sticky overflow and a low-watermark interrupt request in place of the raw !busy interrupt.

---
 rtl/uart_tx_fifo.sv | 130 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU write path and uart_tx. It queues up to DEPTH bytes and
// launches each one into the transmitter's en/data/busy handshake.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned THRESH = 1,
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          flush,
  input  logic          ovf_clr,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          irq_low,
  output logic          idle
);

  localparam int unsigned PW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two in 2..16");
  end
  if (THRESH >= DEPTH) begin : g_bad_thresh
    $error("uart_tx_fifo: THRESH must be below DEPTH");
  end

  typedef enum logic [1:0] {StIdle, StLaunch, StHold, StWait} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [DEPTH];

  logic pop;
  logic push_ok;
  logic push_drop;

  always_comb begin
    // Flush suppresses both the pop and the push of the same cycle.
    pop       = (state_q == StIdle) && (count_q != '0) && !tx_busy && !flush;
    push_ok   = push && !flush && ((count_q < CW'(DEPTH)) || pop);
    push_drop = push && !flush && !push_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push_ok) begin
        count_d = count_q - CW'(1);
      end
    end

    if (push_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    tx_en_d   = pop;
    tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;

    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pop) state_d = StLaunch;
      StLaunch: state_d = StHold;
      // tx_busy only rises the cycle after tx_en, so HOLD skips looking at it.
      StHold:   state_d = StWait;
      StWait:   if (!tx_busy) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array carries no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    tx_en    = tx_en_q;
    tx_data  = tx_data_q;
    count    = count_q;
    overflow = overflow_q;
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    irq_low  = (count_q <= CW'(THRESH));
    idle     = empty && (state_q == StIdle) && !tx_busy;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a busy model stands in for uart_tx and a scoreboard
// queue checks every launched byte against the order in which bytes were accepted.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rstn;
  logic          push;
  logic [7:0]    push_data;
  logic          flush;
  logic          ovf_clr;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          irq_low;
  logic          idle;

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  int busy_len = 20;
  int busy_cnt = 0;
  logic busy_hold = 1'b0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.DEPTH(DEPTH), .THRESH(1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_data),
    .flush     (flush),
    .ovf_clr   (ovf_clr),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .irq_low   (irq_low),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_tx stand-in: busy rises the cycle after tx_en and is reset by the same rstn.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) busy_cnt <= 0;
    else if (tx_en) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_hold | (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1 && tx_en === 1'b1) begin
      tx_seen++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_tx_en: observed tx_data %0h expected no tx_en", tx_data);
      end
      if (exp_q.size() > 0) check("tx_data_order", tx_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accept);
    push      = 1'b1;
    push_data = d;
    if (accept) exp_q.push_back(d);
    step();
    push = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (idle !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, idle, 1);
  endtask

  task automatic wait_count(input string tag, input int v, input int budget);
    int n = 0;
    while (count !== CW'(v) && n < budget) begin
      step();
      n++;
    end
    check(tag, count, v);
  endtask

  task automatic wait_tx(input string tag, input int budget);
    int n = 0;
    while (tx_en !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, tx_en, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_irq_low"}, irq_low, 1);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_tx_en"}, tx_en, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rstn = 1'b0; push = 1'b0; push_data = '0; flush = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rstn = 1'b1;
    step();

    // Single byte: tx_en two edges after the push.
    push_byte(8'h41, 1'b1);
    check("single_count_after_push", count, 1);
    check("single_no_early_tx_en", tx_en, 0);
    step();
    check("single_tx_en", tx_en, 1);
    check("single_count_after_pop", count, 0);
    step();
    check("single_tx_en_one_pulse", tx_en, 0);
    wait_idle("single_idle_timeout", 60);

    // Burst while uart is busy, then overflow behaviour.
    busy_len  = 4;
    busy_hold = 1'b1;
    push_byte(8'h10, 1'b1);
    push_byte(8'h11, 1'b1);
    push_byte(8'h12, 1'b1);
    push_byte(8'h13, 1'b1);
    check("burst_count", count, 4);
    check("burst_full", full, 1);
    check("burst_irq_low", irq_low, 0);
    check("burst_no_tx_while_busy", tx_en, 0);
    push_byte(8'h99, 1'b0);
    check("ovf_count_held", count, 4);
    check("ovf_set", overflow, 1);
    ovf_clr = 1'b1;
    push_byte(8'h9a, 1'b0);
    ovf_clr = 1'b0;
    check("ovf_set_beats_clr", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr_alone", overflow, 0);

    // Busy falls and a push lands in the pop cycle while full.
    busy_hold = 1'b0;
    push_byte(8'h55, 1'b1);
    check("pushpop_count", count, 4);
    check("pushpop_tx_en", tx_en, 1);
    check("pushpop_no_ovf", overflow, 0);
    wait_count("drain_reach2", 2, 60);
    check("drain_irq_low_at2", irq_low, 0);
    wait_count("drain_reach1", 1, 60);
    check("drain_irq_low_at1", irq_low, 1);
    wait_idle("drain_idle_timeout", 80);
    check("drain_scoreboard_empty", exp_q.size(), 0);

    // Flush with push while the first byte is in flight.
    busy_len = 6;
    base = tx_seen;
    push_byte(8'ha0, 1'b1);
    push_byte(8'ha1, 1'b0);
    check("flush_tx_en_a0", tx_en, 1);
    push_byte(8'ha2, 1'b0);
    push_byte(8'ha3, 1'b0);
    check("flush_count_before", count, 3);
    flush = 1'b1;
    push_byte(8'h77, 1'b0);
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_no_ovf", overflow, 0);
    wait_idle("flush_idle_timeout", 40);
    repeat (10) step();
    check("flush_single_tx", tx_seen - base, 1);

    // Ten bytes through a four-entry FIFO wraps the pointers twice.
    busy_len = 2;
    base = tx_seen;
    for (int g = 0; g < 5; g++) begin
      push_byte(8'(2 * g), 1'b1);
      push_byte(8'(2 * g + 1), 1'b1);
      wait_idle("wrap_idle_timeout", 40);
    end
    check("wrap_tx_total", tx_seen - base, 10);
    check("wrap_scoreboard_empty", exp_q.size(), 0);

    // Asynchronous reset in WAIT with a byte still queued.
    busy_len = 10;
    push_byte(8'hc3, 1'b1);
    wait_tx("areset_tx_timeout", 10);
    step();
    step();
    push_byte(8'hc4, 1'b0);
    check("areset_pre_count", count, 1);
    check("areset_pre_busy", tx_busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (15) step();
    check("areset_no_stale_tx", exp_q.size(), 0);
    check("areset_idle_after", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
